dsm_feed_ctrl: RTL and testbench

- Sample-rate controller that sequences the 8-bit input of the delta-sigma DAC modulator in the sine generator.
- Generates the sample-rate tick from the modulator clock and pulls samples from an upstream source over a valid/ready handshake through a one-entry holding register.
- Ramps the modulator input between midscale (128, silence) and the signal on enable/disable, so the analogue output does not pop.
- Detects and counts underruns.

---
 rtl/dsm_feed_ctrl.sv | 149 ++++++++++++++
 tb/tb_dsm_feed_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_feed_ctrl.sv
// Sample-rate sequencer for the delta-sigma DAC modulator input: tick generation,
// one-entry sample holding register, pop-free ramps to/from midscale and underrun counting.
module dsm_feed_ctrl #(
  parameter int          OSR          = 256,
  parameter int          RAMP_STEP    = 1,
  parameter logic [7:0]  MIDSCALE     = 8'd128,
  parameter logic [15:0] UNDERRUN_RST = 16'h0000  // reset value of underrun_cnt, normally 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  dsm_in,
  output logic        sample_tick,
  output logic        underrun,
  output logic [15:0] underrun_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam int                  CNT_W    = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(OSR - 1);
  localparam logic signed [8:0]   STEP_S   = 9'(RAMP_STEP);

  state_t             st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hold_valid_q, hold_valid_d;
  logic [7:0]         hold_data_q;
  logic [7:0]         dsm_q, dsm_d;
  logic [15:0]        ucnt_q;
  logic               tick, accept, under;
  logic [7:0]         ramp_v;

  // Move cur toward tgt by at most RAMP_STEP; the 9-bit signed difference keeps
  // the result inside 0..255 with no overshoot.
  function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [8:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)
      return cur + 8'(RAMP_STEP);
    else if (diff < -STEP_S)
      return cur - 8'(RAMP_STEP);
    else
      return tgt;
  endfunction

  always_comb begin
    tick    = (st_q != IDLE) && (cnt_q == CNT_LAST);
    s_ready = !hold_valid_q && ((st_q == RAMP_UP) || (st_q == RUN));
    accept  = s_valid && s_ready;
  end

  always_comb begin
    st_d         = st_q;
    dsm_d        = dsm_q;
    hold_valid_d = hold_valid_q | accept;
    under        = 1'b0;
    ramp_v       = dsm_q;
    if (st_q == IDLE || cnt_q == CNT_LAST)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;

    case (st_q)
      IDLE: begin
        if (enable) st_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable) begin
          st_d         = RAMP_DOWN;
          hold_valid_d = 1'b0;
        end else if (tick && hold_valid_q) begin
          ramp_v = ramp_toward(dsm_q, hold_data_q);
          dsm_d  = ramp_v;
          if (ramp_v == hold_data_q) begin
            hold_valid_d = 1'b0;
            st_d         = RUN;
          end
        end
      end
      RUN: begin
        // Disable wins over consuming a sample at the same tick.
        if (!enable) begin
          st_d         = RAMP_DOWN;
          hold_valid_d = 1'b0;
        end else if (tick) begin
          if (hold_valid_q) begin
            dsm_d        = hold_data_q;
            hold_valid_d = 1'b0;
          end else begin
            under = 1'b1;
          end
        end
      end
      RAMP_DOWN: begin
        hold_valid_d = 1'b0;
        if (enable) begin
          st_d = RAMP_UP;
        end else if (tick) begin
          ramp_v = ramp_toward(dsm_q, MIDSCALE);
          dsm_d  = ramp_v;
          if (ramp_v == MIDSCALE) begin
            st_d  = IDLE;
            cnt_d = '0;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= IDLE;
      cnt_q        <= '0;
      hold_valid_q <= 1'b0;
      dsm_q        <= MIDSCALE;
      ucnt_q       <= UNDERRUN_RST;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      hold_valid_q <= hold_valid_d;
      dsm_q        <= dsm_d;
      if (under && ucnt_q != 16'hFFFF)
        ucnt_q <= ucnt_q + 16'd1;
    end
  end

  // Sample payload: no reset, qualified by hold_valid_q.
  always_ff @(posedge clk) begin
    if (accept)
      hold_data_q <= s_data;
  end

  assign dsm_in       = dsm_q;
  assign sample_tick  = tick;
  assign underrun     = under;
  assign underrun_cnt = ucnt_q;
  assign state        = st_q;

endmodule

// File: tb/tb_dsm_feed_ctrl.sv
// Scoreboard bench for dsm_feed_ctrl: stimulus pushes per-tick expectations,
// a negedge monitor pops them at each sample_tick and checks dsm_in/state/underrun.
module tb_dsm_feed_ctrl;

  localparam int OSR = 4;

  typedef struct packed {
    logic       under;
    logic [7:0] dsm;
    logic [1:0] st;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, enable, s_valid, s_ready, sample_tick, underrun;
  logic [7:0]  s_data, dsm_in;
  logic [15:0] underrun_cnt;
  logic [1:0]  state;

  logic        en2, sv2, sr2, tick2, und2;
  logic [7:0]  sd2, dsm2;
  logic [15:0] ucnt2;
  logic [1:0]  st2;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t pe;
  logic pend = 1'b0;
  int   run_cyc = 0;

  always #5 clk = ~clk;

  dsm_feed_ctrl #(.OSR(OSR), .RAMP_STEP(16), .MIDSCALE(8'd128)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .dsm_in(dsm_in), .sample_tick(sample_tick), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .state(state)
  );

  dsm_feed_ctrl #(.OSR(2), .RAMP_STEP(16), .MIDSCALE(8'd128), .UNDERRUN_RST(16'hFFFE)) u_sat (
    .clk(clk), .rst(rst), .enable(en2), .s_data(sd2), .s_valid(sv2),
    .s_ready(sr2), .dsm_in(dsm2), .sample_tick(tick2), .underrun(und2),
    .underrun_cnt(ucnt2), .state(st2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic u, input logic [7:0] d, input logic [1:0] s);
    exp_t e;
    e.under = u;
    e.dsm   = d;
    e.st    = s;
    exp_q.push_back(e);
  endtask

  task automatic wait_tick_neg();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_tick) return;
    end
    checks++;
    errors++;
    $display("FAIL tick_timeout actual=none required=tick");
  endtask

  task automatic wait_tick();
    wait_tick_neg();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] v);
    s_data  = v;
    s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("ready_drop_after_accept", s_ready, 0);
        return;
      end
    end
    s_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL accept_timeout actual=none required=handshake");
  endtask

  // Monitor: pop one expectation per tick, check dsm_in/state the cycle after.
  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      chk("tick_dsm", dsm_in, pe.dsm);
      chk("tick_state", state, pe.st);
    end
    if (rst) begin
      run_cyc = 0;
    end else begin
      if (state == 2'd0) run_cyc = 0;
      else run_cyc++;
      if (sample_tick) begin
        chk("tick_phase", (run_cyc != 0 && run_cyc % OSR == 0), 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick actual=tick required=none state=%0d", state);
        end else begin
          pe = exp_q.pop_front();
          chk("underrun_at_tick", underrun, pe.under);
          pend = 1'b1;
        end
      end else begin
        chk("underrun_off_tick", underrun, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    en2 = 1'b0; sv2 = 1'b0; sd2 = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dsm", dsm_in, 128);
    chk("rst_state", state, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_ucnt", underrun_cnt, 0);
    chk("rst_sat_ucnt", ucnt2, 16'hFFFE);
    repeat (12) @(posedge clk);
    #1;

    // Ramp up toward 200
    enable = 1'b1; s_valid = 1'b1; s_data = 8'd200;
    push(0, 144, 1); push(0, 160, 1); push(0, 176, 1); push(0, 192, 1); push(0, 200, 2);
    @(negedge clk);
    chk("idle_before_edge", state, 0);
    @(negedge clk);
    chk("rampup_state", state, 1);
    chk("ready_rise", s_ready, 1);
    @(negedge clk);
    chk("accepted_200", s_ready, 0);
    s_valid = 1'b0;
    repeat (5) wait_tick();

    // Steady run
    offer(8'd10);  push(0, 10, 2);  wait_tick();
    offer(8'd250); push(0, 250, 2); wait_tick();
    offer(8'd0);   push(0, 0, 2);   wait_tick();
    offer(8'd255); push(0, 255, 2); wait_tick();
    chk("steady_ucnt", underrun_cnt, 0);

    // Underrun
    offer(8'd90); push(0, 90, 2); wait_tick();
    push(1, 90, 2); push(1, 90, 2); push(1, 90, 2);
    repeat (3) wait_tick();
    chk("underrun_cnt_3", underrun_cnt, 3);

    // Ramp down with a held sample, then reversal
    offer(8'd40); push(0, 40, 2); wait_tick();
    offer(8'd99);
    enable = 1'b0;
    @(negedge clk);
    chk("rampdown_state", state, 3);
    chk("rampdown_ready", s_ready, 0);
    push(0, 56, 3); push(0, 72, 3);
    repeat (2) wait_tick();
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("reversal_state", state, 1);
    offer(8'd60); push(0, 60, 2); wait_tick();

    // Reset in the middle of a ramp down
    enable = 1'b0;
    push(0, 76, 3); wait_tick();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_dsm", dsm_in, 128);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_tick", sample_tick, 0);
    chk("mid_rst_underrun", underrun, 0);
    chk("mid_rst_ucnt", underrun_cnt, 0);

    // Handshake on the same edge as an underrunning RUN tick
    enable = 1'b1;
    offer(8'd128); push(0, 128, 2); wait_tick();
    push(1, 128, 2); push(0, 77, 2);
    wait_tick_neg();
    s_data = 8'd77; s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    wait_tick();
    chk("simul_ucnt", underrun_cnt, 1);
    enable = 1'b0;
    push(0, 93, 3); push(0, 109, 3); push(0, 125, 3); push(0, 128, 0);
    repeat (4) wait_tick();
    repeat (10) @(posedge clk);
    #1;
    chk("final_idle", state, 0);

    // Saturation of the underrun count
    en2 = 1'b1; sv2 = 1'b1; sd2 = 8'd128;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sr2) break;
    end
    @(posedge clk);
    #1 sv2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("sat_underrun_on_tick", und2 & ~tick2, 0);
    end
    chk("sat_ucnt", ucnt2, 16'hFFFF);
    chk("sat_state", st2, 2);
    chk("sat_dsm", dsm2, 128);
    en2 = 1'b0;

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
